// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and types for the multi-channel PWM generator.
//   NUM_CH_DEF / CNT_W_DEF / PRESC_W_DEF : default parameter values.
//   cnt_dir_e : counter direction, used only when PWM_CENTER_ALIGNED_EN
//               is defined (centre-aligned triangle counting).
package pwm_pkg;

  localparam int unsigned NUM_CH_DEF  = 16;
  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned PRESC_W_DEF = 8;

  typedef enum logic {
    CNT_UP   = 1'b0,
    CNT_DOWN = 1'b1
  } cnt_dir_e;

endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaler, period counter and boundary generation.
//   clk, rst    : clock, asynchronous active-high reset
//   period      : counter terminal value, latched into prd_sh at each boundary
//   presc       : prescaler; one count tick every presc+1 clks
//   cnt         : current counter value
//   boundary    : combinational, high in the clk whose edge wraps the counter
//   period_tick : registered one-clk pulse, aligned with cnt returning to 0
// Optional: PWM_CENTER_ALIGNED_EN selects up/down (triangle) counting.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CNT_W-1:0]   period,
  input  logic [PRESC_W-1:0] presc,
  output logic [CNT_W-1:0]   cnt,
  output logic               boundary,
  output logic               period_tick
);

  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

  logic [PRESC_W-1:0] presc_cnt;
  logic               tick;
  logic [CNT_W-1:0]   prd_sh;

  // >= rather than == so that lowering presc below the running count
  // fires a tick on the next clk instead of waiting for a full wrap.
  assign tick = (presc_cnt >= presc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + PRESC_ONE;
    end
  end

`ifdef PWM_CENTER_ALIGNED_EN
  cnt_dir_e dir;

  // Boundary only on the downward step that lands on 0, so each period is
  // 2*prd_sh ticks. prd_sh = 0 never turns down and wraps every tick.
  always_comb begin
    boundary = 1'b0;
    if (tick) begin
      if (dir == CNT_DOWN) begin
        boundary = (cnt <= CNT_ONE);
      end else begin
        boundary = (prd_sh == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      dir         <= CNT_UP;
      prd_sh      <= '1;
      period_tick <= 1'b0;
    end else begin
      period_tick <= boundary;
      if (boundary) begin
        cnt    <= '0;
        dir    <= CNT_UP;
        prd_sh <= period;
      end else if (tick) begin
        if (dir == CNT_UP) begin
          if (cnt == prd_sh) begin
            dir <= CNT_DOWN;
            cnt <= cnt - CNT_ONE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end else begin
          cnt <= cnt - CNT_ONE;
        end
      end
    end
  end
`else
  always_comb begin
    boundary = tick && (cnt == prd_sh);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      prd_sh      <= '1;
      period_tick <= 1'b0;
    end else begin
      period_tick <= boundary;
      if (boundary) begin
        cnt    <= '0;
        prd_sh <= period;
      end else if (tick) begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end
`endif

endmodule

// File: rtl/pwm_multich.sv
// pwm_multich: parametrised multi-channel PWM generator with double-buffered
// duty registers, programmable period and clock prescaler.
//   clk, rst    : clock, asynchronous active-high reset
//   wr_en       : one-clk duty write strobe
//   wr_sel      : channel index for the write (indices >= NUM_CH are ignored)
//   wr_duty     : duty value written into the active duty register
//   period      : counter terminal value (period = period+1 ticks)
//   presc       : prescaler (one tick every presc+1 clks)
//   out_en      : per-channel output enable
//   pwm_en      : per-channel PWM mode; 0 drives a static high when enabled
//   out         : registered channel outputs
//   period_tick : one-clk pulse on counter wrap
// Optional: PWM_CENTER_ALIGNED_EN selects centre-aligned (triangle) counting.
module pwm_multich
  import pwm_pkg::*;
#(
  parameter  int unsigned NUM_CH  = NUM_CH_DEF,
  parameter  int unsigned CNT_W   = CNT_W_DEF,
  parameter  int unsigned PRESC_W = PRESC_W_DEF,
  localparam int unsigned SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [SEL_W-1:0]   wr_sel,
  input  logic [CNT_W-1:0]   wr_duty,
  input  logic [CNT_W-1:0]   period,
  input  logic [PRESC_W-1:0] presc,
  input  logic [NUM_CH-1:0]  out_en,
  input  logic [NUM_CH-1:0]  pwm_en,
  output logic [NUM_CH-1:0]  out,
  output logic               period_tick
);

  logic [CNT_W-1:0] cnt;
  logic             boundary;
  logic [CNT_W-1:0] duty_act [NUM_CH];
  logic [CNT_W-1:0] duty_sh  [NUM_CH];

  pwm_timebase #(
    .CNT_W   (CNT_W),
    .PRESC_W (PRESC_W)
  ) u_timebase (
    .clk         (clk),
    .rst         (rst),
    .period      (period),
    .presc       (presc),
    .cnt         (cnt),
    .boundary    (boundary),
    .period_tick (period_tick)
  );

  // Matching by loop keeps out-of-range wr_sel from indexing past the array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        duty_act[i] <= '0;
      end
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (wr_sel == SEL_W'(i)) begin
          duty_act[i] <= wr_duty;
        end
      end
    end
  end

  // Shadows sample duty_act before this edge's write, so a write coinciding
  // with the boundary waits for the following boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        duty_sh[i] <= '0;
      end
    end else if (boundary) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        duty_sh[i] <= duty_act[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        out[i] <= out_en[i] & (pwm_en[i] ? (cnt < duty_sh[i]) : 1'b1);
      end
    end
  end

endmodule

// File: tb/tb_pwm_multich.sv
// tb_pwm_multich: randomized and directed self-checking bench for pwm_multich.
// The reference model tracks position within the current period and derives
// the counter value arithmetically from it.
module tb_pwm_multich;

  localparam int NCH = 12;
  localparam int CW  = 8;
  localparam int PW  = 8;
  localparam int SW  = 4;

`ifdef PWM_CENTER_ALIGNED_EN
  localparam int FIRST_BOUNDARY = 510;
`else
  localparam int FIRST_BOUNDARY = 256;
`endif

  logic           clk;
  logic           rst;
  logic           wr_en;
  logic [SW-1:0]  wr_sel;
  logic [CW-1:0]  wr_duty;
  logic [CW-1:0]  period;
  logic [PW-1:0]  presc;
  logic [NCH-1:0] out_en;
  logic [NCH-1:0] pwm_en;
  logic [NCH-1:0] out;
  logic           period_tick;

  pwm_multich #(
    .NUM_CH  (NCH),
    .CNT_W   (CW),
    .PRESC_W (PW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .wr_duty     (wr_duty),
    .period      (period),
    .presc       (presc),
    .out_en      (out_en),
    .pwm_en      (pwm_en),
    .out         (out),
    .period_tick (period_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
  endtask

  // Reference model state
  int             m_since;
  int             m_pos;
  int             m_prd;
  int             m_act [NCH];
  int             m_sh  [NCH];
  logic [NCH-1:0] m_out;
  logic           m_ptick;

  // Window accumulators
  int             acc_ch;
  int             acc_hi;
  int             acc_pt;
  logic [NCH-1:0] acc_and;
  logic [NCH-1:0] acc_or;

  function automatic int len_of(input int prd);
`ifdef PWM_CENTER_ALIGNED_EN
    return (prd == 0) ? 1 : 2 * prd;
`else
    return prd + 1;
`endif
  endfunction

  function automatic int cnt_of(input int pos, input int prd);
`ifdef PWM_CENTER_ALIGNED_EN
    return (pos <= prd) ? pos : 2 * prd - pos;
`else
    return pos;
`endif
  endfunction

  task automatic model_reset();
    m_since = 0;
    m_pos   = 0;
    m_prd   = 255;
    m_out   = '0;
    m_ptick = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      m_act[i] = 0;
      m_sh[i]  = 0;
    end
  endtask

  task automatic acc_clear(input int ch);
    acc_ch  = ch;
    acc_hi  = 0;
    acc_pt  = 0;
    acc_and = '1;
    acc_or  = '0;
  endtask

  // One clk: advance the model with the inputs applied before the edge,
  // then compare both outputs just after the edge.
  task automatic step();
    int  c;
    bit  tk;
    bit  bnd;
    @(posedge clk);
    c   = cnt_of(m_pos, m_prd);
    tk  = (m_since >= int'(presc));
    m_since = tk ? 0 : m_since + 1;
    bnd = tk && (m_pos == len_of(m_prd) - 1);
    for (int i = 0; i < NCH; i++) begin
      m_out[i] = out_en[i] & (pwm_en[i] ? (c < m_sh[i]) : 1'b1);
    end
    m_ptick = bnd;
    if (tk) m_pos = bnd ? 0 : m_pos + 1;
    if (bnd) begin
      m_prd = int'(period);
      for (int i = 0; i < NCH; i++) m_sh[i] = m_act[i];
    end
    if (wr_en && int'(wr_sel) < NCH) m_act[wr_sel] = int'(wr_duty);
    #1;
    check("out", 32'(out), 32'(m_out));
    check("period_tick", 32'(period_tick), 32'(m_ptick));
    acc_hi  += int'(out[acc_ch]);
    acc_pt  += int'(period_tick);
    acc_and &= out;
    acc_or  |= out;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write_duty(input int ch, input int val);
    wr_en   = 1'b1;
    wr_sel  = SW'(ch);
    wr_duty = CW'(val);
    step();
    wr_en   = 1'b0;
  endtask

  // Returns the number of clks until period_tick, bounded.
  task automatic wait_ptick(output int n);
    n = 0;
    while (n < 3000) begin
      step();
      n++;
      if (period_tick) return;
    end
    check("ptick_timeout", 32'(0), 32'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_out", 32'(out), 32'(0));
    check("rst_ptick", 32'(period_tick), 32'(0));
    @(posedge clk);
    #1;
    check("rst_out_hold", 32'(out), 32'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_sel  = '0;
    wr_duty = '0;
    period  = 8'hFF;
    presc   = '0;
    out_en  = '0;
    pwm_en  = '0;
    model_reset();
    acc_clear(0);
    #1;
    check("reset_out", 32'(out), 32'(0));
    check("reset_ptick", 32'(period_tick), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    // Basic 50% duty on ch0, full period, no prescaling
    out_en = 12'h001;
    pwm_en = 12'h001;
    write_duty(0, 8'h80);
    wait_ptick(n);
    check("first_boundary", 32'(n), 32'(FIRST_BOUNDARY - 1));
`ifndef PWM_CENTER_ALIGNED_EN
    acc_clear(0);
    steps(256);
    check("t1_high", 32'(acc_hi), 32'(128));
    check("t1_ticks", 32'(acc_pt), 32'(1));

    // Prescaler 3, period 9, ch1 duty 5
    presc  = 8'd3;
    period = 8'd9;
    out_en = 12'h003;
    pwm_en = 12'h003;
    write_duty(1, 5);
    wait_ptick(n);
    wait_ptick(n);
    check("t2_spacing", 32'(n), 32'(40));
    acc_clear(1);
    steps(40);
    check("t2_high", 32'(acc_hi), 32'(20));
    check("t2_ticks", 32'(acc_pt), 32'(1));

    // Mid-period duty change stays double-buffered
    presc  = 8'd0;
    period = 8'hFF;
    out_en = 12'h004;
    pwm_en = 12'h004;
    write_duty(2, 8'h40);
    wait_ptick(n);
    wait_ptick(n);
    acc_clear(2);
    steps(20);
    write_duty(2, 8'hC0);
    steps(235);
    check("t3_old_high", 32'(acc_hi), 32'(64));
    check("t3_old_ticks", 32'(acc_pt), 32'(1));
    acc_clear(2);
    steps(256);
    check("t3_new_high", 32'(acc_hi), 32'(192));

    // Boundary cases: duty 0, duty > period, static high, disabled,
    // and an out-of-range channel write
    period = 8'hFE;
    write_duty(3, 0);
    write_duty(4, 8'hFF);
    write_duty(6, 8'h80);
    write_duty(12, 8'h55);
    out_en = 12'b0000_0011_1000;
    pwm_en = 12'b0000_0101_1000;
    wait_ptick(n);
    wait_ptick(n);
    acc_clear(4);
    steps(255);
    check("duty0_low", 32'(acc_or[3]), 32'(0));
    check("duty_gt_prd_high", 32'(acc_and[4]), 32'(1));
    check("static_high", 32'(acc_and[5]), 32'(1));
    check("disabled_low", 32'(acc_or[6]), 32'(0));
    check("bad_sel_no_effect", 32'(acc_or), 32'(12'b0000_0011_0000));

    // Reset in the middle of a period
    wait_ptick(n);
    steps(100);
    do_reset();
    out_en = 12'h001;
    pwm_en = 12'h001;
    write_duty(0, 8'h20);
    acc_clear(0);
    wait_ptick(n);
    check("rst_restart_len", 32'(n), 32'(FIRST_BOUNDARY - 1));
    check("rst_shadow_zero", 32'(acc_hi), 32'(0));
`else
    // Triangle counting: period 4, duty 2
    presc  = 8'd0;
    period = 8'd4;
    out_en = 12'h080;
    pwm_en = 12'h080;
    write_duty(7, 2);
    wait_ptick(n);
    wait_ptick(n);
    check("ca_spacing", 32'(n), 32'(8));
    acc_clear(7);
    steps(8);
    check("ca_high", 32'(acc_hi), 32'(3));
    check("ca_ticks", 32'(acc_pt), 32'(1));
    wait_ptick(n);
    steps(3);
    do_reset();
`endif

    // Randomized phase against the model
    for (int it = 0; it < 40; it++) begin
      presc  = PW'($urandom_range(0, 3));
      period = CW'($urandom_range(0, 20));
      out_en = NCH'($urandom);
      pwm_en = NCH'($urandom);
      for (int k = 0; k < 3; k++) begin
        write_duty($urandom_range(0, 15), $urandom_range(0, 24));
      end
      for (int k = 0; k < 60; k++) begin
        if ($urandom_range(0, 15) == 0) write_duty($urandom_range(0, 15), $urandom_range(0, 24));
        else step();
      end
      if ($urandom_range(0, 9) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
